fetch_stage: RTL and testbench

//  IF stage of the stall-model RV32I pipeline: owns the PC, issues instruction-memory reads over a
//  req/gnt/rvalid handshake, buffers returned words in a small FIFO and drives the IF/ID pipeline

---
 rtl/rv32i_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the front end of the stall-model pipeline.
//   NOP_INST       canonical bubble instruction (addi x0, x0, 0)
//   OP_*           major opcode field values (inst[6:0])
//   fetch_entry_t  one buffered fetch result: PC and instruction word
//   word_align     clears the byte-offset bits of an address
package rv32i_pkg;

   localparam logic [31:0] NOP_INST  = 32'h0000_0013;

   localparam logic [6:0]  OP_LUI    = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_REG    = 7'b0110011;
   localparam logic [6:0]  OP_FENCE  = 7'b0001111;
   localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the IF instruction buffer.
//   clk_i, rst_ni   clock and synchronous active-low reset
//   push_i/data_i   write one entry (ignored when full)
//   pop_i           drop the head entry (ignored when empty)
//   clear_i         empty the FIFO; wins over push and pop in the same cycle
//   head_o          current head entry (meaningful when !empty_o)
//   full_o/empty_o  occupancy flags
//   count_o         number of stored entries, 0..DEPTH
// Pointers carry one extra MSB so full and empty are distinguishable when
// the index bits match.
module fetch_fifo
   import rv32i_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  fetch_entry_t           data_i,
   input  logic                   pop_i,
   input  logic                   clear_i,
   output fetch_entry_t           head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   fetch_entry_t mem_q [DEPTH];
   fetch_entry_t mem_d [DEPTH];

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i && !full_o) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues instruction-memory reads, buffers the
// returned words and drives the IF/ID register feeding decode.
//   clk_i, rst_ni          clock and synchronous active-low reset
//   stall_if_i             hold the IF/ID register
//   flush_id_i             load a NOP bubble into the IF/ID register
//   pc_taken_i/target_i    EX-resolved redirect of the fetch stream
//   imem_req_o/addr_o      fetch request and word address
//   imem_gnt_i             request accepted this cycle
//   imem_rvalid_i/rdata_i  in-order read data return
//   inst_d_o/pc_d_o        instruction in ID and its PC
//   valid_d_o              0 when ID holds a bubble
//
// Memory handshake: a request transfers on a cycle where imem_req_o and
// imem_gnt_i are both high; imem_addr_o holds while req is high without gnt.
// Each transfer is answered by exactly one imem_rvalid_i pulse, in order, at
// least one cycle later. There is no backpressure on rvalid, so requests are
// only issued while every in-flight word is guaranteed a FIFO slot.
module fetch_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_if_i,
   input  logic        flush_id_i,
   input  logic        pc_taken_i,
   input  logic [31:0] pc_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_d_o,
   output logic [31:0] pc_d_o,
   output logic        valid_d_o
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [31:0]   id_inst_q, id_inst_d;
   logic [31:0]   id_pc_q, id_pc_d;
   logic          id_valid_q, id_valid_d;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  fifo_head, fifo_wdata;
   logic [CW:0]   credit_used;
   logic          gnt_fire;

   // Credit counts FIFO entries plus every word still in flight, including
   // stale ones that will be discarded, so a push can never find it full.
   assign fifo_pop    = ~flush_id_i & ~stall_if_i & ~fifo_empty;
   assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count}
                      - {{CW{1'b0}}, fifo_pop};
   assign imem_req_o  = rst_ni & ~pc_taken_i & (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_addr_o = pc_q;
   assign gnt_fire    = imem_req_o & imem_gnt_i;

   // Words arriving during a redirect belong to the old stream.
   assign fifo_push   = imem_rvalid_i & (discard_q == '0) & ~pc_taken_i;
   assign fifo_wdata  = '{pc: pc_q - (32'd4 * 32'(outstanding_q)), inst: imem_rdata_i};

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .data_i  (fifo_wdata),
      .pop_i   (fifo_pop),
      .clear_i (pc_taken_i),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid_i);
      discard_d     = discard_q;

      if (pc_taken_i) begin
         pc_d      = word_align(pc_target_i);
         // Everything still in flight after this cycle is from the old path.
         discard_d = outstanding_q - CW'(imem_rvalid_i);
      end else begin
         if (gnt_fire) begin
            pc_d = pc_q + 32'd4;
         end
         if (imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
         end
      end
   end

   // IF/ID register. A redirect alone does not squash ID; the hazard unit
   // asserts flush_id_i alongside pc_taken_i when that is required.
   always_comb begin
      id_inst_d  = id_inst_q;
      id_pc_d    = id_pc_q;
      id_valid_d = id_valid_q;
      if (flush_id_i) begin
         id_inst_d  = NOP_INST;
         id_pc_d    = '0;
         id_valid_d = 1'b0;
      end else if (!stall_if_i) begin
         if (!fifo_empty) begin
            id_inst_d  = fifo_head.inst;
            id_pc_d    = fifo_head.pc;
            id_valid_d = 1'b1;
         end else begin
            id_inst_d  = NOP_INST;
            id_pc_d    = '0;
            id_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_q          <= word_align(RESET_PC);
         outstanding_q <= '0;
         discard_q     <= '0;
         id_inst_q     <= NOP_INST;
         id_pc_q       <= '0;
         id_valid_q    <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         id_inst_q     <= id_inst_d;
         id_pc_q       <= id_pc_d;
         id_valid_q    <= id_valid_d;
      end
   end

   assign inst_d_o  = id_inst_q;
   assign pc_d_o    = id_pc_q;
   assign valid_d_o = id_valid_q;

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fifo_push && fifo_full));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   import rv32i_pkg::*;

   // Returned words are the fetch address xor'ed with a tag so that a PC and
   // an instruction word can never be confused with each other.
   localparam logic [31:0] TAG = 32'hDEAD_0000;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        stall_if_i = 1'b0;
   logic        flush_id_i = 1'b0;
   logic        pc_taken_i = 1'b0;
   logic [31:0] pc_target_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic [31:0] inst_d_o;
   logic [31:0] pc_d_o;
   logic        valid_d_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] pend_q[$];
   logic        rsp_hold = 1'b0;
   logic        mon_prev_rst = 1'b0;
   logic        mon_prev_stall = 1'b0;
   logic        mon_prev_flush = 1'b0;

   fetch_stage #(.FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .stall_if_i    (stall_if_i),
      .flush_id_i    (flush_id_i),
      .pc_taken_i    (pc_taken_i),
      .pc_target_i   (pc_target_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .inst_d_o      (inst_d_o),
      .pc_d_o        (pc_d_o),
      .valid_d_o     (valid_d_o)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_req"},   imem_req_o, 32'd0);
      check({pfx, "_valid"}, valid_d_o,  32'd0);
      check({pfx, "_inst"},  inst_d_o,   NOP_INST);
      check({pfx, "_pc"},    pc_d_o,     32'd0);
   endtask

   // Leaves the bench at the start of cycle 0: first cycle out of reset.
   task automatic do_reset();
      rst_ni      = 1'b0;
      stall_if_i  = 1'b0;
      flush_id_i  = 1'b0;
      pc_taken_i  = 1'b0;
      pc_target_i = '0;
      imem_gnt_i  = 1'b1;
      rsp_hold    = 1'b0;
      exp_q.delete();
      cyc();
      @(negedge clk_i);
      check_reset_vals("rst");
      cyc();
      rst_ni = 1'b1;
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      logic [31:0] a;
      a = start;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(a);
         a = a + 32'd4;
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
      check(tag, exp_q.size(), 32'd0);
   endtask

   // ---------------- instruction memory model ----------------
   // Answers each accepted request one cycle later unless rsp_hold is set.
   initial begin
      forever begin
         @(posedge clk_i);
         #2;
         if (rst_ni && !rsp_hold && pend_q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = pend_q.pop_front() ^ TAG;
         end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
         end
         @(negedge clk_i);
         if (!rst_ni) pend_q.delete();
         else if (imem_req_o && imem_gnt_i) pend_q.push_back(imem_addr_o);
      end
   end

   // ---------------- scoreboard ----------------
   // Compares every instruction newly loaded into ID against the expected
   // PC stream; held (stalled) and flushed cycles are not new loads.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk_i);
         if (mon_prev_rst && !mon_prev_stall && !mon_prev_flush && valid_d_o &&
             exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_pc",   pc_d_o,   e);
            check("sb_inst", inst_d_o, e ^ TAG);
         end
         mon_prev_rst   = rst_ni;
         mon_prev_stall = stall_if_i;
         mon_prev_flush = flush_id_i;
      end
   end

   // ---------------- directed tests ----------------
   initial begin
      // 1: streaming from reset, one instruction per cycle
      do_reset();
      push_seq(32'h0, 8);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_i);
         check("t1_req",   imem_req_o,  32'd1);
         check("t1_addr",  imem_addr_o, 32'(4 * k));
         check("t1_valid", valid_d_o,   32'(k >= 3));
         cyc();
      end
      wait_drain("t1_drain", 20);

      // 2: stall holds ID at pc 8, credit stops requests, release resumes
      do_reset();
      push_seq(32'h0, 12);
      for (int k = 0; k < 12; k++) begin
         stall_if_i = (k >= 5 && k <= 7);
         @(negedge clk_i);
         if (k >= 5 && k <= 8) begin
            check("t2_hold_pc",    pc_d_o,    32'h8);
            check("t2_hold_inst",  inst_d_o,  32'h8 ^ TAG);
            check("t2_hold_valid", valid_d_o, 32'd1);
         end
         if (k == 7) check("t2_req_stop", imem_req_o, 32'd0);
         if (k == 8) begin
            check("t2_req_resume", imem_req_o,  32'd1);
            check("t2_addr_resume", imem_addr_o, 32'd28);
         end
         if (k == 9) check("t2_next_pc", pc_d_o, 32'd12);
         cyc();
      end
      stall_if_i = 1'b0;
      wait_drain("t2_drain", 20);

      // 3: redirect with two words in flight (one returns that same cycle)
      do_reset();
      push_seq(32'h100, 4);
      for (int k = 0; k < 9; k++) begin
         rsp_hold    = (k < 2);
         pc_taken_i  = (k == 2);
         stall_if_i  = (k == 2);
         pc_target_i = 32'h100;
         @(negedge clk_i);
         if (k == 2) check("t3_req_redirect", imem_req_o, 32'd0);
         if (k == 3) begin
            check("t3_req_new",  imem_req_o,  32'd1);
            check("t3_addr_new", imem_addr_o, 32'h100);
         end
         if (k >= 3 && k <= 5) check("t3_bubble", valid_d_o, 32'd0);
         if (k == 6) begin
            check("t3_first_valid", valid_d_o, 32'd1);
            check("t3_first_pc",    pc_d_o,    32'h100);
         end
         cyc();
      end
      pc_taken_i = 1'b0;
      stall_if_i = 1'b0;
      wait_drain("t3_drain", 20);

      // 4: flush together with stall gives a bubble and keeps the FIFO head
      do_reset();
      push_seq(32'h0, 8);
      for (int k = 0; k < 8; k++) begin
         flush_id_i = (k == 4);
         stall_if_i = (k == 4);
         @(negedge clk_i);
         if (k == 4) check("t4_pre_pc", pc_d_o, 32'd4);
         if (k == 5) begin
            check("t4_nop_inst",  inst_d_o,  NOP_INST);
            check("t4_nop_valid", valid_d_o, 32'd0);
         end
         if (k == 6) begin
            check("t4_head_pc",    pc_d_o,    32'd8);
            check("t4_head_valid", valid_d_o, 32'd1);
         end
         cyc();
      end
      flush_id_i = 1'b0;
      stall_if_i = 1'b0;
      wait_drain("t4_drain", 20);

      // 5: grant withheld for five cycles
      do_reset();
      push_seq(32'h0, 8);
      for (int k = 0; k < 14; k++) begin
         imem_gnt_i = !(k >= 4 && k <= 8);
         @(negedge clk_i);
         if (k >= 4 && k <= 9) begin
            check("t5_req_held",  imem_req_o,  32'd1);
            check("t5_addr_held", imem_addr_o, 32'd16);
         end
         if (k >= 7 && k <= 11) check("t5_drained", valid_d_o, 32'd0);
         if (k == 12) begin
            check("t5_resume_pc",    pc_d_o,    32'd16);
            check("t5_resume_valid", valid_d_o, 32'd1);
         end
         cyc();
      end
      imem_gnt_i = 1'b1;
      wait_drain("t5_drain", 20);

      // 6: unaligned redirect near the top of memory, then reset mid-stream
      do_reset();
      push_seq(32'hFFFF_FFFC, 3);
      for (int k = 0; k < 9; k++) begin
         pc_taken_i  = (k == 2);
         flush_id_i  = (k == 2);
         pc_target_i = 32'hFFFF_FFFE;
         rst_ni      = (k != 8);
         @(negedge clk_i);
         if (k == 2) check("t6_req_redirect", imem_req_o, 32'd0);
         if (k == 3) check("t6_addr_top",  imem_addr_o, 32'hFFFF_FFFC);
         if (k == 4) check("t6_addr_wrap", imem_addr_o, 32'h0);
         if (k == 6) check("t6_pc_top",  pc_d_o, 32'hFFFF_FFFC);
         if (k == 7) check("t6_pc_wrap", pc_d_o, 32'h0);
         cyc();
      end
      pc_taken_i = 1'b0;
      flush_id_i = 1'b0;
      wait_drain("t6_drain_a", 0);
      @(negedge clk_i);
      check_reset_vals("t6_rst");
      cyc();
      rst_ni = 1'b1;
      push_seq(32'h0, 3);
      @(negedge clk_i);
      check("t6_first_req",  imem_req_o,  32'd1);
      check("t6_first_addr", imem_addr_o, 32'h0);
      cyc();
      wait_drain("t6_drain_b", 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
